branch_resolution_unit: RTL and testbench

//  Execute-side partner of branch_predictor: records each prediction as its branch leaves DECODE and

---
 rtl/branch_resolution_unit_pkg.sv | 28 ++
 rtl/branch_resolution_unit_fifo.sv | 90 +++++++++
 rtl/branch_resolution_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolution_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolution_unit_pkg.sv
// Shared definitions for the branch resolution unit: address widths,
// the layout of an in-flight branch entry, FIFO control states and the
// sequential fall-through helper.
package branch_resolution_unit_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_BYTES = 4;
    localparam int ENTRY_W    = 2 * ADDR_W + 1;

    // Entry layout, MSB first: branch PC, predicted direction, predicted target
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              predTaken;
        logic [ADDR_W-1:0] predTarget;
    } bru_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_t;

    // Address of the instruction following a branch (wraps modulo 2^ADDR_W)
    function automatic logic [ADDR_W-1:0] fallThrough(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(INST_BYTES);
    endfunction

endpackage

// File: rtl/branch_resolution_unit_fifo.sv
// Circular queue of in-flight branch entries. The head is visible
// combinationally so EXEC can compare against it in the same cycle it pops.
// Full/empty come from a small registered state machine; a clear request
// empties the queue and takes priority over any push.
module bru_fifo
    import branch_resolution_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_clear,
    input  logic [ENTRY_W-1:0] i_wdata,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]    r_rdPtr;
    logic [PTR_W-1:0]    r_wrPtr;
    logic [CNT_BITS-1:0] r_count;
    fifo_state_t         r_state;
    logic [CNT_BITS-1:0] w_countNext;

    // Occupancy after this cycle's push/pop (clear handled in the sequential block)
    always_comb begin
        w_countNext = r_count;
        case ({i_push, i_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    // Entry storage; a push on a full queue with a pop reuses the slot just read
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer, count and EMPTY/PARTIAL/FULL state machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_state <= FIFO_EMPTY;
        end else if (i_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_state <= FIFO_EMPTY;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= w_countNext;
            case (r_state)
                FIFO_EMPTY,
                FIFO_PARTIAL,
                FIFO_FULL: begin
                    if (w_countNext == '0) begin
                        r_state <= FIFO_EMPTY;
                    end else if (w_countNext == FULL_COUNT) begin
                        r_state <= FIFO_FULL;
                    end else begin
                        r_state <= FIFO_PARTIAL;
                    end
                end
                default: r_state <= FIFO_EMPTY;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_full  = (r_state == FIFO_FULL);
    assign o_empty = (r_state == FIFO_EMPTY);

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: remembers each prediction as its branch leaves
// DECODE, checks it against the real outcome in EXEC, and produces the
// predictor training feedback plus the fetch redirect on a misprediction.
// A misprediction discards every younger queued branch (they are wrong-path).
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_is_branch,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic              d_pred_taken,
    input  logic [ADDR_W-1:0] d_pred_target,
    input  logic              x_resolve,
    input  logic              x_taken,
    input  logic [ADDR_W-1:0] x_target,
    input  logic              flush,
    output logic              d_stall,
    output logic              x_predict_res,
    output logic              fb_valid,
    output logic [ADDR_W-1:0] fb_pc,
    output logic [ADDR_W-1:0] fb_target,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              orphan_err,
    output logic [CNT_W-1:0]  resolved_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    logic [ENTRY_W-1:0] w_headRaw;
    bru_entry_t         w_head;
    bru_entry_t         w_newEntry;
    logic               w_full;
    logic               w_empty;
    logic               w_predWrong;
    logic               w_pop;
    logic               w_mispredict;
    logic               w_push;
    logic               w_clear;
    logic [ADDR_W-1:0]  w_actualNext;

    logic               r_fbValid;
    logic               r_predictRes;
    logic [ADDR_W-1:0]  r_fbPc;
    logic [ADDR_W-1:0]  r_fbTarget;
    logic               r_redirectValid;
    logic [ADDR_W-1:0]  r_redirectPc;
    logic               r_orphanErr;
    logic [CNT_W-1:0]   r_resolvedCnt;
    logic [CNT_W-1:0]   r_mispredCnt;

    assign w_head = bru_entry_t'(w_headRaw);

    // Compare the oldest prediction against the real outcome and decide push/pop/clear
    always_comb begin
        w_newEntry            = '0;
        w_newEntry.pc         = d_pc;
        w_newEntry.predTaken  = d_pred_taken;
        w_newEntry.predTarget = d_pred_target;

        w_predWrong  = (w_head.predTaken != x_taken) |
                       (x_taken & w_head.predTaken & (w_head.predTarget != x_target));
        w_pop        = x_resolve & ~w_empty;
        w_mispredict = w_pop & w_predWrong;
        d_stall      = w_full & ~(x_resolve & ~w_predWrong);
        w_push       = d_is_branch & ~d_stall & ~flush & ~w_mispredict;
        w_clear      = flush | w_mispredict;
        w_actualNext = x_taken ? x_target : fallThrough(w_head.pc);
    end

    bru_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_wdata (w_newEntry),
        .o_head  (w_headRaw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // One-cycle feedback/redirect pulses, sticky orphan flag and saturating statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fbValid       <= 1'b0;
            r_predictRes    <= 1'b0;
            r_fbPc          <= '0;
            r_fbTarget      <= '0;
            r_redirectValid <= 1'b0;
            r_redirectPc    <= '0;
            r_orphanErr     <= 1'b0;
            r_resolvedCnt   <= '0;
            r_mispredCnt    <= '0;
        end else begin
            r_fbValid       <= w_pop;
            r_predictRes    <= w_pop ? x_taken : 1'b0;
            r_fbPc          <= w_pop ? w_head.pc : '0;
            r_fbTarget      <= w_pop ? w_actualNext : '0;
            r_redirectValid <= w_mispredict & ~flush;
            r_redirectPc    <= (w_mispredict & ~flush) ? w_actualNext : '0;
            if (x_resolve & w_empty) begin
                r_orphanErr <= 1'b1;
            end
            if (w_pop && (r_resolvedCnt != '1)) begin
                r_resolvedCnt <= r_resolvedCnt + 1'b1;
            end
            if (w_mispredict && (r_mispredCnt != '1)) begin
                r_mispredCnt <= r_mispredCnt + 1'b1;
            end
        end
    end

    assign fb_valid       = r_fbValid;
    assign x_predict_res  = r_predictRes;
    assign fb_pc          = r_fbPc;
    assign fb_target      = r_fbTarget;
    assign redirect_valid = r_redirectValid;
    assign redirect_pc    = r_redirectPc;
    assign orphan_err     = r_orphanErr;
    assign resolved_cnt   = r_resolvedCnt;
    assign mispred_cnt    = r_mispredCnt;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit. A reference queue model
// predicts every cycle's feedback/redirect; predictions are pushed to a
// scoreboard when stimulus is driven and popped when the registered outputs
// appear after the clock edge.
module tb_branch_resolution_unit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              d_is_branch = 1'b0;
    logic [31:0]       d_pc = '0;
    logic              d_pred_taken = 1'b0;
    logic [31:0]       d_pred_target = '0;
    logic              x_resolve = 1'b0;
    logic              x_taken = 1'b0;
    logic [31:0]       x_target = '0;
    logic              flush = 1'b0;
    logic              d_stall;
    logic              x_predict_res;
    logic              fb_valid;
    logic [31:0]       fb_pc;
    logic [31:0]       fb_target;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              orphan_err;
    logic [CNT_W-1:0]  resolved_cnt;
    logic [CNT_W-1:0]  mispred_cnt;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
    } modelEntry_t;

    typedef struct {
        logic        isReset;
        logic        fbValid;
        logic [31:0] fbPc;
        logic        res;
        logic [31:0] fbTgt;
        logic        rdValid;
        logic [31:0] rdPc;
    } expResult_t;

    modelEntry_t modelQ[$];
    expResult_t  scoreboard[$];
    logic        modelOrphan = 1'b0;
    int          modelResolved = 0;
    int          modelMispred = 0;
    int          totalChecks = 0;
    int          badChecks = 0;

    always #5 clk = ~clk;

    branch_resolution_unit #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .d_is_branch    (d_is_branch),
        .d_pc           (d_pc),
        .d_pred_taken   (d_pred_taken),
        .d_pred_target  (d_pred_target),
        .x_resolve      (x_resolve),
        .x_taken        (x_taken),
        .x_target       (x_target),
        .flush          (flush),
        .d_stall        (d_stall),
        .x_predict_res  (x_predict_res),
        .fb_valid       (fb_valid),
        .fb_pc          (fb_pc),
        .fb_target      (fb_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .orphan_err     (orphan_err),
        .resolved_cnt   (resolved_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Pop the prediction for the edge just taken and compare registered outputs
    task automatic checkCycle();
        expResult_t e;
        if (scoreboard.size() == 0) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL sb_underflow: got empty scoreboard expected one entry");
            return;
        end
        e = scoreboard.pop_front();
        checkOutput("fb_valid", {63'd0, fb_valid}, {63'd0, e.fbValid});
        if (e.fbValid) begin
            checkOutput("fb_pc", {32'd0, fb_pc}, {32'd0, e.fbPc});
            checkOutput("x_predict_res", {63'd0, x_predict_res}, {63'd0, e.res});
            checkOutput("fb_target", {32'd0, fb_target}, {32'd0, e.fbTgt});
        end
        checkOutput("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.rdValid});
        if (e.rdValid) begin
            checkOutput("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.rdPc});
        end
        if (e.isReset) begin
            checkOutput("rst_fb_pc", {32'd0, fb_pc}, 64'd0);
            checkOutput("rst_fb_target", {32'd0, fb_target}, 64'd0);
            checkOutput("rst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
            checkOutput("rst_x_predict_res", {63'd0, x_predict_res}, 64'd0);
        end
        checkOutput("orphan_err", {63'd0, orphan_err}, {63'd0, modelOrphan});
        checkOutput("resolved_cnt", {48'd0, resolved_cnt}, 64'(modelResolved));
        checkOutput("mispred_cnt", {48'd0, mispred_cnt}, 64'(modelMispred));
    endtask

    // Drive one cycle of inputs, predict its effect, then check after the edge
    task automatic applyStimulus(input logic isBr, input logic [31:0] pc, input logic pt,
                                 input logic [31:0] ptgt, input logic res, input logic tk,
                                 input logic [31:0] tgt, input logic fl, input logic rstIn);
        expResult_t  e;
        modelEntry_t h;
        logic        expStall;
        logic        wrong;
        logic        pop;
        logic        misp;

        @(negedge clk);
        rst_n         = rstIn;
        d_is_branch   = isBr;
        d_pc          = pc;
        d_pred_taken  = pt;
        d_pred_target = ptgt;
        x_resolve     = res;
        x_taken       = tk;
        x_target      = tgt;
        flush         = fl;
        #1;

        h     = '{pc: 32'd0, pt: 1'b0, ptgt: 32'd0};
        wrong = 1'b0;
        if (modelQ.size() != 0) begin
            h     = modelQ[0];
            wrong = (h.pt != tk) || (tk && h.pt && (h.ptgt != tgt));
        end
        expStall = (modelQ.size() == DEPTH) && !(res && !wrong);
        if (rstIn) begin
            checkOutput("d_stall", {63'd0, d_stall}, {63'd0, expStall});
        end
        pop  = res && (modelQ.size() != 0);
        misp = pop && wrong;

        e = '{isReset: 1'b0, fbValid: 1'b0, fbPc: 32'd0, res: 1'b0, fbTgt: 32'd0, rdValid: 1'b0, rdPc: 32'd0};
        if (!rstIn) begin
            e.isReset = 1'b1;
            modelQ.delete();
            modelOrphan   = 1'b0;
            modelResolved = 0;
            modelMispred  = 0;
        end else begin
            if (res && (modelQ.size() == 0)) begin
                modelOrphan = 1'b1;
            end
            if (pop) begin
                e.fbValid = 1'b1;
                e.fbPc    = h.pc;
                e.res     = tk;
                e.fbTgt   = tk ? tgt : h.pc + 32'd4;
                e.rdValid = misp && !fl;
                e.rdPc    = e.rdValid ? e.fbTgt : 32'd0;
                void'(modelQ.pop_front());
                if (modelResolved < 65535) modelResolved++;
                if (misp && (modelMispred < 65535)) modelMispred++;
            end
            if (misp || fl) begin
                modelQ.delete();
            end else if (isBr && !expStall) begin
                modelQ.push_back('{pc: pc, pt: pt, ptgt: ptgt});
            end
        end
        scoreboard.push_back(e);

        @(posedge clk);
        #1;
        checkCycle();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic pushBranch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        applyStimulus(1'b1, pc, pt, ptgt, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic resolveBranch(input logic tk, input logic [31:0] tgt);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, tk, tgt, 1'b0, 1'b1);
    endtask

    initial begin
        logic        rIsBr;
        logic        rPt;
        logic        rRes;
        logic        rTk;
        logic        rFl;
        logic [31:0] rPtgt;
        logic [31:0] rTgt;

        $display("[TB] reset");
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] correctly predicted taken branch");
        pushBranch(32'h1014, 1'b1, 32'h1000);
        resolveBranch(1'b1, 32'h1000);
        idleCycle();

        $display("[TB] not-taken mispredict flushes younger entry");
        pushBranch(32'h1008, 1'b1, 32'h1010);
        pushBranch(32'h100c, 1'b0, 32'h0);
        resolveBranch(1'b0, 32'h0);

        $display("[TB] full queue, push with correct pop");
        pushBranch(32'h2000, 1'b0, 32'h0);
        pushBranch(32'h2004, 1'b0, 32'h0);
        pushBranch(32'h2008, 1'b0, 32'h0);
        pushBranch(32'h200c, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h2010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        pushBranch(32'h2014, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) resolveBranch(1'b0, 32'h0);
        idleCycle();

        $display("[TB] taken with wrong target");
        pushBranch(32'h3000, 1'b1, 32'h1000);
        resolveBranch(1'b1, 32'h1020);
        idleCycle();

        $display("[TB] corner cases");
        resolveBranch(1'b0, 32'h0);
        idleCycle();
        idleCycle();
        pushBranch(32'h4000, 1'b0, 32'h0);
        pushBranch(32'h4004, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h4008, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1);
        idleCycle();
        pushBranch(32'h4100, 1'b0, 32'h0);
        pushBranch(32'h4104, 1'b0, 32'h0);
        pushBranch(32'h4108, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        pushBranch(32'h4200, 1'b1, 32'h4300);
        resolveBranch(1'b1, 32'h4300);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            rIsBr = 1'($urandom_range(0, 1));
            rPt   = 1'($urandom_range(0, 1));
            rPtgt = ($urandom_range(0, 1) == 0) ? 32'h7000 : 32'h7010;
            rRes  = ($urandom_range(0, 2) == 0);
            rTk   = 1'($urandom_range(0, 1));
            rTgt  = ($urandom_range(0, 1) == 0) ? 32'h7000 : 32'h7010;
            rFl   = ($urandom_range(0, 15) == 0);
            applyStimulus(rIsBr, 32'h6000 + 32'(i * 4), rPt, rPtgt, rRes, rTk, rTgt, rFl, 1'b1);
        end
        idleCycle();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
